// File: rtl/dtw_word_assembler_if.sv
// Bus bundle between the word assembler and its neighbours: the glove classifier,
// the DTW matcher and the display/UART side.
interface dtw_word_assembler_if;
    logic         i_char_valid;
    logic [7:0]   i_char;
    logic         o_char_ready;
    logic         o_DTW_start;
    logic [119:0] o_DTW_word;
    logic         i_DTW_finish;
    logic [119:0] i_DTW_word;
    logic         o_word_valid;
    logic [119:0] o_word;
    logic [3:0]   o_length;
    logic         o_overflow;
    logic         o_timeout;
    logic [1:0]   o_state;

    modport slave (
        input  i_char_valid, i_char, i_DTW_finish, i_DTW_word,
        output o_char_ready, o_DTW_start, o_DTW_word, o_word_valid, o_word,
               o_length, o_overflow, o_timeout, o_state
    );

    modport master (
        output i_char_valid, i_char, i_DTW_finish, i_DTW_word,
        input  o_char_ready, o_DTW_start, o_DTW_word, o_word_valid, o_word,
               o_length, o_overflow, o_timeout, o_state
    );
endinterface

// File: rtl/dtw_word_assembler.sv
// Packs classifier character codes into a 15-character word, launches the DTW
// matcher on end-of-word and republishes the matcher's corrected word.
module dtw_word_assembler #(
    parameter int MAX_CHARS      = 15,
    parameter bit DEDUP_EN       = 1'b1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                i_DTW_clk,
    input  logic                i_DTW_rst_n,
    dtw_word_assembler_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_START   = 2'd1,
        S_WAIT    = 2'd2,
        S_OUT     = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [MAX_CHARS-1:0][7:0]     buf_q;
    logic [3:0]                    len_q;
    logic [7:0]                    last_q;
    logic                          ovf_q;
    logic                          tmo_q;
    logic [CNT_W-1:0]              cnt_q;
    logic [119:0]                  word_q;

    logic accept, is_letter, is_bs, is_eow, is_gap, is_dup, cnt_done;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign accept    = bus.i_char_valid && (state_q == S_COLLECT);
    assign is_letter = (bus.i_char >= 8'h41) && (bus.i_char <= 8'h5A);
    assign is_bs     = (bus.i_char == 8'h08);
    assign is_eow    = (bus.i_char == 8'h20) || (bus.i_char == 8'h0D);
    assign is_gap    = (bus.i_char == 8'h00);
    assign is_dup    = DEDUP_EN && (bus.i_char == last_q);
    assign cnt_done  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_DTW_clk or posedge i_DTW_rst_n) begin
        if (i_DTW_rst_n) state_q <= S_COLLECT;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COLLECT: if (accept && is_eow && (len_q != 4'd0)) state_d = S_START;
            S_START:   state_d = S_WAIT;
            S_WAIT: begin
                if (bus.i_DTW_finish)  state_d = S_OUT;
                else if (cnt_done)     state_d = S_COLLECT;
            end
            S_OUT:     state_d = S_COLLECT;
            default:   state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge i_DTW_clk or posedge i_DTW_rst_n) begin
        if (i_DTW_rst_n) begin
            buf_q  <= '0;
            len_q  <= 4'd0;
            last_q <= 8'h00;
            ovf_q  <= 1'b0;
            tmo_q  <= 1'b0;
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            tmo_q <= 1'b0;
            case (state_q)
                S_COLLECT: begin
                    if (accept) begin
                        if (is_letter) begin
                            if ((len_q < 4'(MAX_CHARS)) && !is_dup) begin
                                buf_q[len_q] <= bus.i_char;
                                len_q        <= sat_inc(len_q);
                                last_q       <= bus.i_char;
                            end else if (len_q == 4'(MAX_CHARS)) begin
                                ovf_q <= 1'b1;
                            end
                        end else if (is_bs) begin
                            // Unused bytes must stay zero so the matcher's nonzero count matches length.
                            if (len_q != 4'd0) begin
                                buf_q[len_q - 4'd1] <= 8'h00;
                                len_q               <= len_q - 4'd1;
                                last_q              <= 8'h00;
                            end
                        end else if (is_gap) begin
                            last_q <= 8'h00;
                        end
                    end
                end
                S_START: cnt_q <= '0;
                S_WAIT: begin
                    if (bus.i_DTW_finish) begin
                        word_q <= bus.i_DTW_word;
                    end else if (cnt_done) begin
                        buf_q  <= '0;
                        len_q  <= 4'd0;
                        last_q <= 8'h00;
                        ovf_q  <= 1'b0;
                        tmo_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_OUT: begin
                    buf_q  <= '0;
                    len_q  <= 4'd0;
                    last_q <= 8'h00;
                    ovf_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_char_ready = (state_q == S_COLLECT);
    assign bus.o_DTW_start  = (state_q == S_START);
    assign bus.o_word_valid = (state_q == S_OUT);
    assign bus.o_DTW_word   = buf_q;
    assign bus.o_word       = word_q;
    assign bus.o_length     = len_q;
    assign bus.o_overflow   = ovf_q;
    assign bus.o_timeout    = tmo_q;
    assign bus.o_state      = state_q;

endmodule

// File: tb/tb_dtw_word_assembler.sv
// Directed bench for dtw_word_assembler: packing, dedup, backspace, overflow,
// matcher handshake, timeout and reset during a wait.
module tb_dtw_word_assembler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [119:0] exp_word;
    logic [119:0] exp_buf;

    dtw_word_assembler_if bus();

    dtw_word_assembler #(.MAX_CHARS(15), .DEDUP_EN(1'b1), .TIMEOUT_CYCLES(4096)) dut (
        .i_DTW_clk  (clk),
        .i_DTW_rst_n(rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        bus.i_char_valid = 1'b1;
        bus.i_char       = c;
        tick();
        bus.i_char_valid = 1'b0;
        bus.i_char       = 8'h00;
    endtask

    task automatic finish_with(input logic [119:0] w);
        bus.i_DTW_finish = 1'b1;
        bus.i_DTW_word   = w;
        tick();
        bus.i_DTW_finish = 1'b0;
        bus.i_DTW_word   = '0;
    endtask

    task automatic test_reset();
        tick();
        checks++; if (bus.o_state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", bus.o_state); end
        checks++; if (bus.o_length !== 4'd0) begin failures++; $display("FAIL rst_len got=%0d exp=0", bus.o_length); end
        checks++; if (bus.o_word !== 120'd0) begin failures++; $display("FAIL rst_word got=%h exp=0", bus.o_word); end
        checks++; if (bus.o_DTW_word !== 120'd0) begin failures++; $display("FAIL rst_dtw_word got=%h exp=0", bus.o_DTW_word); end
        checks++; if ({bus.o_DTW_start, bus.o_word_valid, bus.o_overflow, bus.o_timeout} !== 4'b0000)
            begin failures++; $display("FAIL rst_pulses got=%b exp=0000", {bus.o_DTW_start, bus.o_word_valid, bus.o_overflow, bus.o_timeout}); end
        checks++; if (bus.o_char_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", bus.o_char_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_hello();
        send(8'h48); send(8'h45); send(8'h4C); send(8'h4C); send(8'h4F);
        checks++; if (bus.o_length !== 4'd4) begin failures++; $display("FAIL hello_len got=%0d exp=4", bus.o_length); end
        checks++; if (bus.o_DTW_word !== 120'h4F4C4548) begin failures++; $display("FAIL hello_pack got=%h exp=4f4c4548", bus.o_DTW_word); end
        send(8'h20);
        checks++; if (bus.o_DTW_start !== 1'b1 || bus.o_state !== 2'd1) begin failures++; $display("FAIL hello_start got=%b/%0d exp=1/1", bus.o_DTW_start, bus.o_state); end
        tick();
        checks++; if (bus.o_DTW_start !== 1'b0 || bus.o_state !== 2'd2) begin failures++; $display("FAIL hello_wait got=%b/%0d exp=0/2", bus.o_DTW_start, bus.o_state); end
        exp_word = 120'h4F4C4C4548;
        finish_with(exp_word);
        checks++; if (bus.o_word_valid !== 1'b1) begin failures++; $display("FAIL hello_valid got=%b exp=1", bus.o_word_valid); end
        checks++; if (bus.o_word !== exp_word) begin failures++; $display("FAIL hello_word got=%h exp=%h", bus.o_word, exp_word); end
        tick();
        checks++; if (bus.o_word_valid !== 1'b0 || bus.o_length !== 4'd0 || bus.o_state !== 2'd0)
            begin failures++; $display("FAIL hello_after got=%b/%0d/%0d exp=0/0/0", bus.o_word_valid, bus.o_length, bus.o_state); end
        checks++; if (bus.o_DTW_word !== 120'd0) begin failures++; $display("FAIL hello_clear got=%h exp=0", bus.o_DTW_word); end
    endtask

    task automatic test_gap_dedup();
        send(8'h4C); send(8'h00); send(8'h4C);
        checks++; if (bus.o_length !== 4'd2) begin failures++; $display("FAIL gap_len got=%0d exp=2", bus.o_length); end
        checks++; if (bus.o_DTW_word !== 120'h4C4C) begin failures++; $display("FAIL gap_pack got=%h exp=4c4c", bus.o_DTW_word); end
        send(8'h20);
        checks++; if (bus.o_DTW_start !== 1'b1) begin failures++; $display("FAIL gap_start got=%b exp=1", bus.o_DTW_start); end
        tick();
        exp_word = 120'h4C4C;
        finish_with(exp_word);
        tick();
    endtask

    task automatic test_overflow();
        exp_buf = '0;
        for (int i = 0; i < 15; i++) exp_buf[8*i +: 8] = 8'h41;
        for (int i = 0; i < 16; i++) begin
            send(8'h41);
            send(8'h00);
        end
        checks++; if (bus.o_length !== 4'd15) begin failures++; $display("FAIL ovf_len got=%0d exp=15", bus.o_length); end
        checks++; if (bus.o_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", bus.o_overflow); end
        checks++; if (bus.o_DTW_word !== exp_buf) begin failures++; $display("FAIL ovf_pack got=%h exp=%h", bus.o_DTW_word, exp_buf); end
        send(8'h0D);
        tick();
        exp_word = 120'h4141414141;
        finish_with(exp_word);
        checks++; if (bus.o_overflow !== 1'b1) begin failures++; $display("FAIL ovf_held got=%b exp=1", bus.o_overflow); end
        tick();
        checks++; if (bus.o_overflow !== 1'b0 || bus.o_length !== 4'd0) begin failures++; $display("FAIL ovf_clear got=%b/%0d exp=0/0", bus.o_overflow, bus.o_length); end
    endtask

    task automatic test_backspace();
        send(8'h41); send(8'h42);
        checks++; if (bus.o_DTW_word !== 120'h4241) begin failures++; $display("FAIL bs_pre got=%h exp=4241", bus.o_DTW_word); end
        send(8'h08);
        checks++; if (bus.o_DTW_word !== 120'h41 || bus.o_length !== 4'd1) begin failures++; $display("FAIL bs_one got=%h/%0d exp=41/1", bus.o_DTW_word, bus.o_length); end
        send(8'h08); send(8'h08);
        checks++; if (bus.o_DTW_word !== 120'd0 || bus.o_length !== 4'd0) begin failures++; $display("FAIL bs_empty got=%h/%0d exp=0/0", bus.o_DTW_word, bus.o_length); end
        send(8'h20);
        checks++; if (bus.o_DTW_start !== 1'b0 || bus.o_state !== 2'd0) begin failures++; $display("FAIL bs_eow got=%b/%0d exp=0/0", bus.o_DTW_start, bus.o_state); end
    endtask

    task automatic test_timeout();
        int n;
        send(8'h41);
        send(8'h20);
        checks++; if (bus.o_DTW_start !== 1'b1) begin failures++; $display("FAIL tmo_start got=%b exp=1", bus.o_DTW_start); end
        n = 0;
        while (bus.o_timeout !== 1'b1 && n < 5000) begin
            bus.i_char_valid = (n >= 2 && n < 5);
            bus.i_char       = (n >= 2 && n < 5) ? 8'h42 : 8'h00;
            tick();
            n++;
            if (n == 10) begin
                checks++; if (bus.o_length !== 4'd1 || bus.o_char_ready !== 1'b0)
                    begin failures++; $display("FAIL tmo_ignore got=%0d/%b exp=1/0", bus.o_length, bus.o_char_ready); end
            end
        end
        bus.i_char_valid = 1'b0;
        checks++; if (n !== 4097) begin failures++; $display("FAIL tmo_latency got=%0d exp=4097", n); end
        checks++; if (bus.o_state !== 2'd0 || bus.o_char_ready !== 1'b1) begin failures++; $display("FAIL tmo_state got=%0d/%b exp=0/1", bus.o_state, bus.o_char_ready); end
        checks++; if (bus.o_word !== exp_word) begin failures++; $display("FAIL tmo_word got=%h exp=%h", bus.o_word, exp_word); end
        checks++; if (bus.o_length !== 4'd0 || bus.o_DTW_word !== 120'd0) begin failures++; $display("FAIL tmo_clear got=%0d/%h exp=0/0", bus.o_length, bus.o_DTW_word); end
        tick();
        checks++; if (bus.o_timeout !== 1'b0) begin failures++; $display("FAIL tmo_pulse got=%b exp=0", bus.o_timeout); end
    endtask

    task automatic test_reset_mid_wait();
        send(8'h43);
        send(8'h20);
        tick();
        tick();
        checks++; if (bus.o_state !== 2'd2) begin failures++; $display("FAIL rmid_wait got=%0d exp=2", bus.o_state); end
        rst = 1'b1;
        #1;
        checks++; if (bus.o_state !== 2'd0 || bus.o_length !== 4'd0) begin failures++; $display("FAIL rmid_async got=%0d/%0d exp=0/0", bus.o_state, bus.o_length); end
        tick();
        rst = 1'b0;
        bus.i_DTW_finish = 1'b1;
        bus.i_DTW_word   = 120'h5A5A;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.o_word_valid !== 1'b0 || bus.o_state !== 2'd0) begin failures++; $display("FAIL rmid_novalid got=%b/%0d exp=0/0", bus.o_word_valid, bus.o_state); end
        end
        bus.i_DTW_finish = 1'b0;
        checks++; if (bus.o_word !== 120'd0) begin failures++; $display("FAIL rmid_word got=%h exp=0", bus.o_word); end
    endtask

    initial begin
        bus.i_char_valid = 1'b0;
        bus.i_char       = 8'h00;
        bus.i_DTW_finish = 1'b0;
        bus.i_DTW_word   = '0;
        exp_word         = '0;
        exp_buf          = '0;
        test_reset();
        test_hello();
        test_gap_dedup();
        test_overflow();
        test_backspace();
        test_timeout();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
